lcd_ctrl: RTL and testbench

LCD_CTRL -- requirements
Module: lcd_ctrl

---
 rtl/lcd_ctrl.sv | 178 +++++++++++++++++
 tb/tb_lcd_ctrl.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/lcd_ctrl.sv
// HD44780-style character LCD write controller: runs the power-up init
// sequence, then issues single command/data writes with setup, enable and settle timing.
module lcd_ctrl #(
  parameter int PWRUP_CYC = 16,
  parameter int SETUP_CYC = 2,
  parameter int EN_CYC    = 4,
  parameter int CMD_CYC   = 8,
  parameter int CLR_CYC   = 32
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic        i_req_vld,
  input  logic        i_req_rs,
  input  logic [7:0]  i_req_data,
  output logic        o_req_rdy,
  output logic        o_init_done,
  output logic [31:0] o_io_lcd
);

  typedef enum logic [2:0] {
    PWRUP,
    INIT_SETUP,
    INIT_EN,
    INIT_WAIT,
    IDLE,
    SETUP,
    EN,
    WAIT
  } state_t;

  // Terminal counts: a phase of N cycles ends on the edge where the counter reads N-1.
  localparam logic [19:0] PWRUP_LAST = 20'(PWRUP_CYC - 1);
  localparam logic [19:0] SETUP_LAST = 20'(SETUP_CYC - 1);
  localparam logic [19:0] EN_LAST    = 20'(EN_CYC - 1);
  localparam logic [19:0] CMD_LAST   = 20'(CMD_CYC - 1);
  localparam logic [19:0] CLR_LAST   = 20'(CLR_CYC - 1);

  state_t      state_q;
  logic [19:0] cnt_q;
  logic [1:0]  idx_q;
  logic        on_q;
  logic        en_q;
  logic        rs_q;
  logic [7:0]  data_q;
  logic        rdy_q;
  logic        done_q;
  logic [19:0] wait_last_d;

  function automatic logic [7:0] init_cmd(input logic [1:0] idx);
    logic [7:0] cmd;
    case (idx)
      2'd0:    cmd = 8'h38;
      2'd1:    cmd = 8'h0C;
      2'd2:    cmd = 8'h01;
      default: cmd = 8'h06;
    endcase
    return cmd;
  endfunction

  // Clear (0x01) and home (0x02/0x03) need the long settle time; the init
  // sequence uses the same rule since its 0x01 is the only such command.
  always_comb begin
    wait_last_d = CMD_LAST;
    if (!rs_q && (data_q[7:2] == 6'd0)) begin
      wait_last_d = CLR_LAST;
    end
  end

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      state_q <= PWRUP;
      cnt_q   <= 20'd0;
      idx_q   <= 2'd0;
      on_q    <= 1'b0;
      en_q    <= 1'b0;
      rs_q    <= 1'b0;
      data_q  <= 8'd0;
      rdy_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      on_q <= 1'b1;
      case (state_q)
        PWRUP: begin
          if (cnt_q == PWRUP_LAST) begin
            cnt_q   <= 20'd0;
            idx_q   <= 2'd0;
            rs_q    <= 1'b0;
            data_q  <= init_cmd(2'd0);
            state_q <= INIT_SETUP;
          end else begin
            cnt_q <= cnt_q + 20'd1;
          end
        end
        INIT_SETUP: begin
          if (cnt_q == SETUP_LAST) begin
            cnt_q   <= 20'd0;
            en_q    <= 1'b1;
            state_q <= INIT_EN;
          end else begin
            cnt_q <= cnt_q + 20'd1;
          end
        end
        INIT_EN: begin
          if (cnt_q == EN_LAST) begin
            cnt_q   <= 20'd0;
            en_q    <= 1'b0;
            state_q <= INIT_WAIT;
          end else begin
            cnt_q <= cnt_q + 20'd1;
          end
        end
        INIT_WAIT: begin
          if (cnt_q == wait_last_d) begin
            cnt_q <= 20'd0;
            if (idx_q == 2'd3) begin
              rdy_q   <= 1'b1;
              done_q  <= 1'b1;
              state_q <= IDLE;
            end else begin
              idx_q   <= idx_q + 2'd1;
              data_q  <= init_cmd(idx_q + 2'd1);
              state_q <= INIT_SETUP;
            end
          end else begin
            cnt_q <= cnt_q + 20'd1;
          end
        end
        IDLE: begin
          if (i_req_vld) begin
            rs_q    <= i_req_rs;
            data_q  <= i_req_data;
            rdy_q   <= 1'b0;
            cnt_q   <= 20'd0;
            state_q <= SETUP;
          end
        end
        SETUP: begin
          if (cnt_q == SETUP_LAST) begin
            cnt_q   <= 20'd0;
            en_q    <= 1'b1;
            state_q <= EN;
          end else begin
            cnt_q <= cnt_q + 20'd1;
          end
        end
        EN: begin
          if (cnt_q == EN_LAST) begin
            cnt_q   <= 20'd0;
            en_q    <= 1'b0;
            state_q <= WAIT;
          end else begin
            cnt_q <= cnt_q + 20'd1;
          end
        end
        WAIT: begin
          if (cnt_q == wait_last_d) begin
            cnt_q   <= 20'd0;
            rdy_q   <= 1'b1;
            state_q <= IDLE;
          end else begin
            cnt_q <= cnt_q + 20'd1;
          end
        end
        default: begin
          cnt_q   <= 20'd0;
          en_q    <= 1'b0;
          rdy_q   <= 1'b0;
          state_q <= PWRUP;
        end
      endcase
    end
  end

  assign o_req_rdy   = rdy_q;
  assign o_init_done = done_q;
  assign o_io_lcd    = {on_q, 20'd0, en_q, rs_q, 1'b0, data_q};

endmodule

// File: tb/tb_lcd_ctrl.sv
// Scoreboard bench for lcd_ctrl: a cycle-level timeline model predicts every EN
// pulse and the ready/done levels; a monitor compares the LCD pins every cycle.
module tb_lcd_ctrl;
  localparam int PWRUP = 16;
  localparam int SETUP = 2;
  localparam int ENW   = 4;
  localparam int CMDW  = 8;
  localparam int CLRW  = 32;
  localparam int NEVER = 1 << 30;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        vld = 1'b0;
  logic        rs = 1'b0;
  logic [7:0]  data = 8'd0;
  logic        rdy;
  logic        done;
  logic [31:0] io;

  lcd_ctrl dut (
    .i_clk      (clk),
    .i_reset    (rst_n),
    .i_req_vld  (vld),
    .i_req_rs   (rs),
    .i_req_data (data),
    .o_req_rdy  (rdy),
    .o_init_done(done),
    .o_io_lcd   (io)
  );

  always #5 clk = ~clk;

  typedef struct {
    int         rise;
    int         fall;
    logic       rs;
    logic [7:0] data;
  } wr_t;

  wr_t expq[$];
  int  cyc = 0;
  int  ready_from = NEVER;
  int  done_from = NEVER;
  int  n_cmp = 0;
  int  n_bad = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, act, exp);
    end
  endtask

  function automatic int wait_len(input logic r, input logic [7:0] d);
    if (!r && (d == 8'h01 || d == 8'h02 || d == 8'h03 || d == 8'h00)) return CLRW;
    return CMDW;
  endfunction

  // A write whose setup starts on edge a pulses EN over edges [a+SETUP, a+SETUP+ENW).
  task automatic push_write(input int a, input logic r, input logic [7:0] d);
    wr_t w;
    w.rise = a + SETUP;
    w.fall = a + SETUP + ENW;
    w.rs   = r;
    w.data = d;
    expq.push_back(w);
  endtask

  task automatic model_init(input int r);
    logic [7:0] cmds [4];
    int s;
    cmds[0] = 8'h38; cmds[1] = 8'h0C; cmds[2] = 8'h01; cmds[3] = 8'h06;
    s = r + PWRUP;
    for (int i = 0; i < 4; i++) begin
      push_write(s, 1'b0, cmds[i]);
      s = s + SETUP + ENW + wait_len(1'b0, cmds[i]);
    end
    ready_from = s;
    done_from  = s;
  endtask

  task automatic drive(input logic v, input logic r, input logic [7:0] d);
    @(posedge clk);
    #2;
    vld = v; rs = r; data = d;
    if (v && rst_n && cyc >= ready_from) begin
      push_write(cyc + 1, r, d);
      ready_from = cyc + 1 + SETUP + ENW + wait_len(r, d);
    end
  endtask

  task automatic issue(input logic r, input logic [7:0] d, output int acc);
    acc = -1;
    for (int k = 0; k < 200; k++) begin
      @(posedge clk);
      #2;
      if (rst_n && cyc >= ready_from) begin
        vld = 1'b1; rs = r; data = d;
        acc = cyc + 1;
        push_write(acc, r, d);
        ready_from = acc + SETUP + ENW + wait_len(r, d);
        break;
      end
      vld = 1'b0;
    end
    if (acc < 0) check("issue_timeout", 32'd1, 32'd0);
  endtask

  initial begin
    logic       pen;
    logic       act;
    logic       have_last;
    logic       lrs;
    logic [7:0] ldata;
    wr_t        cur;
    pen = 1'b0; act = 1'b0; have_last = 1'b0; lrs = 1'b0; ldata = 8'd0;
    cur.rise = 0; cur.fall = 0; cur.rs = 1'b0; cur.data = 8'd0;
    forever begin
      @(posedge clk);
      #1;
      if (!rst_n) begin
        check("reset_io", io, 32'd0);
        check("reset_rdy", 32'(rdy), 32'd0);
        check("reset_done", 32'(done), 32'd0);
        pen = 1'b0; act = 1'b0; have_last = 1'b0;
      end else begin
        check("rw_bit", 32'(io[8]), 32'd0);
        check("reserved_bits", 32'(io[30:11]), 32'd0);
        check("on_bit", 32'(io[31]), 32'd1);
        check("rdy", 32'(rdy), 32'(cyc >= ready_from));
        check("init_done", 32'(done), 32'(cyc >= done_from));
        if (io[10] && !pen) begin
          if (expq.size() == 0) begin
            check("spurious_en", 32'd1, 32'd0);
            act = 1'b0;
          end else begin
            cur = expq.pop_front();
            act = 1'b1;
            check("en_rise_cycle", 32'(cyc), 32'(cur.rise));
            check("write_rs", 32'(io[9]), 32'(cur.rs));
            check("write_data", 32'(io[7:0]), 32'(cur.data));
            have_last = 1'b1; lrs = cur.rs; ldata = cur.data;
          end
        end else if (io[10] && act) begin
          check("en_hold_rs", 32'(io[9]), 32'(lrs));
          check("en_hold_data", 32'(io[7:0]), 32'(ldata));
        end else if (!io[10] && pen && act) begin
          check("en_fall_cycle", 32'(cyc), 32'(cur.fall));
          act = 1'b0;
        end
        // After a pulse the bus must hold until the next write's setup begins.
        if (have_last && !io[10] && (expq.size() == 0 || cyc < expq[0].rise - SETUP)) begin
          check("post_hold_rs", 32'(io[9]), 32'(lrs));
          check("post_hold_data", 32'(io[7:0]), 32'(ldata));
        end
        pen = io[10];
      end
    end
  end

  initial begin
    int acc;
    #1 rst_n = 1'b0;
    repeat (3) @(posedge clk);

    // Release with a request held valid all through init and beyond.
    @(posedge clk);
    #2;
    rst_n = 1'b1; vld = 1'b1; rs = 1'b1; data = 8'h55;
    model_init(cyc);
    repeat (140) drive(1'b1, 1'b1, 8'h55);
    drive(1'b0, 1'b0, 8'h00);

    issue(1'b1, 8'h41, acc);
    issue(1'b0, 8'h01, acc);
    issue(1'b0, 8'h80, acc);
    issue(1'b0, 8'h02, acc);
    issue(1'b0, 8'h03, acc);
    issue(1'b0, 8'h04, acc);
    issue(1'b1, 8'h00, acc);
    drive(1'b0, 1'b0, 8'h00);

    for (int i = 0; i < 600; i++) begin
      logic       v;
      logic       r;
      logic [7:0] d;
      v = ($urandom_range(3) == 0);
      r = 1'(($urandom & 1));
      d = ($urandom_range(2) == 0) ? 8'($urandom_range(4)) : 8'($urandom_range(255));
      drive(v, r, d);
    end
    drive(1'b0, 1'b0, 8'h00);

    // Reset while EN is high, then a full re-init and one more write.
    issue(1'b1, 8'hA5, acc);
    @(posedge clk);
    #2;
    vld = 1'b0;
    while (cyc < acc + SETUP + 1) begin
      @(posedge clk);
      #2;
    end
    rst_n = 1'b0;
    #1;
    check("reset_during_en_io", io, 32'd0);
    expq.delete();
    ready_from = NEVER;
    done_from  = NEVER;
    repeat (3) @(posedge clk);
    #2;
    rst_n = 1'b1;
    model_init(cyc);
    repeat (110) drive(1'b0, 1'b0, 8'h00);
    issue(1'b1, 8'h7E, acc);
    repeat (40) drive(1'b0, 1'b0, 8'h00);

    check("pending_writes", 32'(expq.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
